// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// Module  : pc_fetch_unit_pkg
// Purpose : Shared front-end pipeline constants and the IF/ID payload type.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

    localparam int          PKG_PC_W  = 9;
    localparam int          PKG_INS_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // IF/ID payload as seen by the decode stage
    typedef struct packed {
        logic [PKG_PC_W-1:0]  pc;
        logic [PKG_INS_W-1:0] instr;
        logic                 valid;
    } if_id_t;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// ============================================================================
// Module  : pc_next_sel
// Purpose : Next-PC priority mux: redirect > stall > increment (wraps mod 2^PC_W).
//           Optional alignment of redirect targets under PC_FETCH_MISALIGN_CHK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_next_sel
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W = 9
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            pcsel_i,
    input  logic            stall_i,
    input  logic [31:0]     brpc_i,
    output logic [PC_W-1:0] pc_next_o
`ifdef PC_FETCH_MISALIGN_CHK_EN
    ,
    output logic            misalign_o
`endif
);

    logic [PC_W-1:0] w_target;
    // Target bits above the PC width are dropped by design
    logic            w_brpc_hi_unused;

    assign w_brpc_hi_unused = ^brpc_i[31:PC_W];

`ifdef PC_FETCH_MISALIGN_CHK_EN
    assign misalign_o = pcsel_i & (brpc_i[1:0] != 2'b00);
    assign w_target   = {brpc_i[PC_W-1:2], 2'b00};
`else
    assign w_target   = brpc_i[PC_W-1:0];
`endif

    always_comb begin
        pc_next_o = pc_i + PC_STEP[PC_W-1:0];
        if (pcsel_i) begin
            pc_next_o = w_target;
        end else if (stall_i) begin
            pc_next_o = pc_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module  : pc_fetch_unit
// Purpose : PC register, imem address and IF/ID register with bubble insertion.
//           Optional misaligned-target check: define PC_FETCH_MISALIGN_CHK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              PC_W  = 9,
    parameter int              INS_W = 32,
    parameter logic [INS_W-1:0] NOP  = NOP_INSTR[INS_W-1:0]
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic [INS_W-1:0] Instr_in,
    output logic [PC_W-1:0]  PC_out,
    output logic [PC_W-1:0]  IfId_PC,
    output logic [INS_W-1:0] IfId_Instr,
    output logic             IfId_Valid,
    output logic             Flush
`ifdef PC_FETCH_MISALIGN_CHK_EN
    ,
    output logic             Misalign_Err
`endif
);

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [PC_W-1:0]  ifid_pc_q;
    logic [INS_W-1:0] ifid_instr_q;
    logic             ifid_valid_q;
    logic             flush_q;

`ifdef PC_FETCH_MISALIGN_CHK_EN
    logic             w_misalign;
    logic             misalign_q;
`endif

    pc_next_sel #(
        .PC_W       (PC_W)
    ) u_pc_next_sel (
        .pc_i       (pc_q),
        .pcsel_i    (PcSel),
        .stall_i    (Stall),
        .brpc_i     (BrPC),
        .pc_next_o  (pc_d)
`ifdef PC_FETCH_MISALIGN_CHK_EN
        ,
        .misalign_o (w_misalign)
`endif
    );

    // Redirect outranks stall: a stalled fetch is on the wrong path once a branch resolves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= PcSel;
            if (PcSel) begin
                ifid_pc_q    <= pc_q;
                ifid_instr_q <= NOP;
                ifid_valid_q <= 1'b0;
            end else if (!Stall) begin
                ifid_pc_q    <= pc_q;
                ifid_instr_q <= Instr_in;
                ifid_valid_q <= 1'b1;
            end
        end
    end

`ifdef PC_FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (w_misalign) begin
            misalign_q <= 1'b1;
        end
    end

    assign Misalign_Err = misalign_q;
`endif

    assign PC_out     = pc_q;
    assign IfId_PC    = ifid_pc_q;
    assign IfId_Instr = ifid_instr_q;
    assign IfId_Valid = ifid_valid_q;
    assign Flush      = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module  : tb_pc_fetch_unit
// Purpose : Self-checking bench for pc_fetch_unit (model + directed vectors).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam logic [31:0] C_NOP  = 32'h0000_0013;
    localparam logic [31:0] C_BASE = 32'hA000_0000;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        PcSel;
    logic [31:0] BrPC;
    logic [31:0] Instr_in;
    logic [8:0]  PC_out;
    logic [8:0]  IfId_PC;
    logic [31:0] IfId_Instr;
    logic        IfId_Valid;
    logic        Flush;
`ifdef PC_FETCH_MISALIGN_CHK_EN
    logic        Misalign_Err;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 0;

    // Model state
    int          m_pc;
    int          m_ifpc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_flush;
    bit          m_err;

    pc_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .PcSel        (PcSel),
        .BrPC         (BrPC),
        .Instr_in     (Instr_in),
        .PC_out       (PC_out),
        .IfId_PC      (IfId_PC),
        .IfId_Instr   (IfId_Instr),
        .IfId_Valid   (IfId_Valid),
        .Flush        (Flush)
`ifdef PC_FETCH_MISALIGN_CHK_EN
        ,
        .Misalign_Err (Misalign_Err)
`endif
    );

    // imem: word at byte address k is 0xA000_0000 + k
    assign Instr_in = C_BASE + {23'd0, PC_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the fetch stage
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 0; m_ifpc = 0; m_instr = C_NOP; m_valid = 0; m_flush = 0; m_err = 0;
        end else begin
            if (PcSel) begin
                int t;
                t = int'(BrPC % 512);
`ifdef PC_FETCH_MISALIGN_CHK_EN
                if (t % 4 != 0) begin
                    t = t - (t % 4);
                    m_err = 1;
                end
`endif
                m_ifpc = m_pc; m_instr = C_NOP; m_valid = 0; m_pc = t;
            end else if (!Stall) begin
                m_ifpc = m_pc; m_instr = C_BASE + m_pc; m_valid = 1;
                m_pc = (m_pc + 4) % 512;
            end
            m_flush = PcSel;
        end
    end

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            chk("model PC_out",     {23'd0, PC_out},  m_pc);
            chk("model IfId_PC",    {23'd0, IfId_PC}, m_ifpc);
            chk("model IfId_Instr", IfId_Instr,       m_instr);
            chk("model IfId_Valid", {31'd0, IfId_Valid}, {31'd0, m_valid});
            chk("model Flush",      {31'd0, Flush},   {31'd0, m_flush});
`ifdef PC_FETCH_MISALIGN_CHK_EN
            chk("model Misalign_Err", {31'd0, Misalign_Err}, {31'd0, m_err});
`endif
        end
    end

    task automatic cyc(input bit sel, input bit st, input logic [31:0] br);
        PcSel = sel; Stall = st; BrPC = br;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " PC_out"},     {23'd0, PC_out},  32'h0);
        chk({tag, " IfId_PC"},    {23'd0, IfId_PC}, 32'h0);
        chk({tag, " IfId_Instr"}, IfId_Instr,       C_NOP);
        chk({tag, " IfId_Valid"}, {31'd0, IfId_Valid}, 32'h0);
        chk({tag, " Flush"},      {31'd0, Flush},   32'h0);
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; PcSel = 1'b0; BrPC = '0;
        #1;
        chk_reset_vals("por");
        @(negedge clk); @(negedge clk);
        reset = 1'b0; chk_on = 1'b1;

        // Free run from 0
        cyc(0, 0, 0);
        chk("run PC_out e1",   {23'd0, PC_out}, 32'h004);
        chk("run IfId_Instr e1", IfId_Instr, 32'hA000_0000);
        chk("run IfId_Valid e1", {31'd0, IfId_Valid}, 32'h1);
        cyc(0, 0, 0);
        chk("run PC_out e2",   {23'd0, PC_out}, 32'h008);
        chk("run IfId_PC e2",  {23'd0, IfId_PC}, 32'h004);
        cyc(0, 0, 0);
        chk("run PC_out e3",   {23'd0, PC_out}, 32'h00C);
        cyc(0, 0, 0);
        chk("run PC_out e4",   {23'd0, PC_out}, 32'h010);

        // Stall for 3 cycles at 0x010
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0);
            chk("stall PC_out",     {23'd0, PC_out}, 32'h010);
            chk("stall IfId_Instr", IfId_Instr, 32'hA000_000C);
        end
        cyc(0, 0, 0);
        chk("unstall PC_out", {23'd0, PC_out}, 32'h014);
        chk("unstall IfId_PC", {23'd0, IfId_PC}, 32'h010);

        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("pre-br PC_out", {23'd0, PC_out}, 32'h020);

        // Redirect to 0x040
        cyc(1, 0, 32'h0000_0040);
        chk("br PC_out",     {23'd0, PC_out}, 32'h040);
        chk("br IfId_Valid", {31'd0, IfId_Valid}, 32'h0);
        chk("br IfId_Instr", IfId_Instr, C_NOP);
        chk("br Flush",      {31'd0, Flush}, 32'h1);
        cyc(0, 0, 0);
        chk("post-br IfId_Instr", IfId_Instr, 32'hA000_0040);
        chk("post-br Flush",      {31'd0, Flush}, 32'h0);

        // Redirect beats stall, then back-to-back with truncation
        cyc(1, 1, 32'h0000_0100);
        chk("br+stall PC_out", {23'd0, PC_out}, 32'h100);
        chk("br+stall IfId_Valid", {31'd0, IfId_Valid}, 32'h0);
        cyc(1, 0, 32'hFFFF_F104);
        chk("trunc PC_out", {23'd0, PC_out}, 32'h104);
        chk("b2b IfId_Valid", {31'd0, IfId_Valid}, 32'h0);

        // Wrap
        cyc(1, 0, 32'h0000_01FC);
        cyc(0, 0, 0);
        chk("wrap PC_out", {23'd0, PC_out}, 32'h000);
        chk("wrap IfId_PC", {23'd0, IfId_PC}, 32'h1FC);

        // Misaligned redirect, then aligned redirect
        cyc(1, 0, 32'h0000_0046);
`ifdef PC_FETCH_MISALIGN_CHK_EN
        chk("misalign PC_out", {23'd0, PC_out}, 32'h044);
        chk("misalign err", {31'd0, Misalign_Err}, 32'h1);
`else
        chk("misalign PC_out", {23'd0, PC_out}, 32'h046);
`endif
        cyc(1, 0, 32'h0000_0080);
        cyc(0, 0, 0);
`ifdef PC_FETCH_MISALIGN_CHK_EN
        chk("sticky err", {31'd0, Misalign_Err}, 32'h1);
`endif
        chk("realign PC_out", {23'd0, PC_out}, 32'h084);

        // Async reset mid-redirect/stall, no clock edge
        cyc(1, 1, 32'h0000_0120);
        chk("pre-rst Flush", {31'd0, Flush}, 32'h1);
        #2 reset = 1'b1; chk_on = 1'b0;
        #1;
        chk_reset_vals("async");
`ifdef PC_FETCH_MISALIGN_CHK_EN
        chk("async Misalign_Err", {31'd0, Misalign_Err}, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0; PcSel = 1'b0; Stall = 1'b0; chk_on = 1'b1;
        cyc(0, 0, 0);
        chk("rst-resume PC_out", {23'd0, PC_out}, 32'h004);
        chk("rst-resume IfId_Valid", {31'd0, IfId_Valid}, 32'h1);
        cyc(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the branch-redirect interface. Takes the PcSel/BrPC pair from the EX-stage branch unit and the stall request from the hazard unit.
- Owns the PC register, drives the instruction-memory address, and holds the IF/ID pipeline register, including its valid bit and bubble insertion.
- Sits at the front of the 5-stage RISC-V pipeline. It feeds the branch unit's Cur_PC two stages later via IF/ID and ID/EX.

Parameters:
- PC_W, 9, width of the PC register and of the instruction-memory byte address.
- INS_W, 32, instruction width.
- NOP, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush and reset.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hazard unit load-use stall: hold PC and IF/ID.
- PcSel  in  1  redirect request from branch unit (1 = taken branch or jalr).
- BrPC  in  32  redirect target byte address from branch unit.
- Instr_in  in  INS_W  instruction read combinationally from imem at PC_out.
- PC_out  out  PC_W  current fetch address to imem.
- IfId_PC  out  PC_W  PC of the instruction held in IF/ID.
- IfId_Instr  out  INS_W  instruction held in IF/ID.
- IfId_Valid  out  1  IF/ID holds a real (non-bubble) instruction.
- Flush  out  1  registered copy of the redirect, used by ID/EX to squash one cycle later.

Behaviour:
- Reset (async, immediate):
  - PC=0, IfId_PC=0, IfId_Instr=NOP, IfId_Valid=0, Flush=0.
  - First rising edge after reset deassertion latches the instruction at address 0 into IF/ID.
- Next-PC priority, evaluated each rising edge:
  - PcSel=1: PC <= BrPC[PC_W-1:0]. BrPC[31:PC_W] is ignored (silent truncation).
  - Else Stall=1: PC holds.
  - Else: PC <= PC+4, modulo 2^PC_W. Wrap 0x1FC -> 0x000 is silent.
- Redirect outranks stall: a stalled instruction is on the wrong path when a branch resolves.
- IF/ID register, same priority:
  - PcSel=1: IfId_Instr<=NOP, IfId_Valid<=0, IfId_PC<=PC (don't-care value, but defined).
  - Else Stall=1: IfId_PC, IfId_Instr and IfId_Valid all hold.
  - Else: IfId_PC<=PC, IfId_Instr<=Instr_in, IfId_Valid<=1.
- Flush: Flush <= PcSel every edge, not gated by Stall. Asserts for exactly one cycle per redirect cycle.
- Branch penalty: 2 cycles. The instruction in IF/ID is squashed here; the instruction in ID at redirect time is squashed by the ID/EX stage using PcSel directly. Flush is the registered copy for any later squash needs.
- Back-to-back PcSel (redirect in consecutive cycles): each cycle redirects independently and IF/ID stays a bubble. No internal state beyond the registers above.
- Stall held for N cycles: PC_out and IF/ID are constant for all N cycles. Fetch resumes at PC+4 on the first cycle with Stall=0.
- Reset asserted mid-redirect or mid-stall: all registers return to reset values immediately. The pending redirect is discarded.
- Misaligned BrPC ([1:0]!=0) is passed through unchanged unless the optional feature is compiled in.

Optional Feature:
- Macro: PC_FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output Misalign_Err (1 bit, reset 0).
  - On an edge with PcSel=1 and BrPC[1:0]!=0, the PC loads {BrPC[PC_W-1:2],2'b00} and Misalign_Err is set.
  - Misalign_Err is sticky until reset.
- Undefined: port absent. BrPC low bits are loaded verbatim.

Decomposition:
- Shared pipeline package:
  - NOP_INSTR constant.
  - PC_STEP (4) constant.
  - An if_id_t packed struct {pc, instr, valid} reused by the ID stage.
- One natural sub-module: pc_next_sel. It is the combinational priority mux (redirect/stall/increment) plus wrap and alignment handling. The PC register and the IF/ID register stay in the parent.

Test Plan:
- Reset then run free, imem word at addr k = 0xA000_0000+k: PC_out sequences 0,4,8,12; IfId_PC lags by one cycle; IfId_Valid goes 0 then 1 after the first edge.
- Stall=1 for 3 cycles with PC=0x010: PC_out stays 0x010 and IF/ID stays frozen; first free cycle gives PC_out=0x014.
- PcSel=1 with BrPC=0x0000_0040 at PC=0x020: next PC_out=0x040, IfId_Valid=0 and IfId_Instr=NOP for one cycle, Flush=1 for one cycle, then valid fetch of 0x040.
- PcSel=1 and Stall=1 together, BrPC=0x100: the redirect wins, giving PC_out=0x100 and an IF/ID bubble. Also BrPC=0xFFFF_F104 loads 0x104 (truncation).
- Wrap: PC=0x1FC with no stall gives next PC_out=0x000. Reset pulsed asynchronously mid-stall resets all outputs without a clock edge.
- With PC_FETCH_MISALIGN_CHK_EN: BrPC=0x0000_0046 loads PC=0x044 and Misalign_Err=1, which stays 1 across a later aligned redirect until reset.
